// File: rtl/game_pkg.sv
// Shared types for the game scheduler: FSM state encoding, period width and
// the saturating period arithmetic used by the speed block.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RUN        = 3'd1,
        WAIT_APPLE = 3'd2,
        WAIT_DONE  = 3'd3,
        PAUSE      = 3'd4,
        FAIL       = 3'd5,
        WIN        = 3'd6
    } game_state_t;

    localparam int PERIOD_W = 4;

    function automatic logic [PERIOD_W-1:0] sat_period(
        input logic [PERIOD_W-1:0] cur,
        input int                  delta,
        input int                  lo,
        input int                  hi
    );
        int sum;
        sum = int'(cur) + delta;
        if (sum < lo) sum = lo;
        else if (sum > hi) sum = hi;
        return sum[PERIOD_W-1:0];
    endfunction

endpackage

// File: rtl/game_sched_if.sv
// Game-flow signal bundle between the frame/snake/apple logic (master) and
// the scheduler (slave).
interface game_sched_if #(
    parameter int SCORE_W = 8
);
    import game_pkg::*;

    logic                i_vsync;
    logic                i_start;
    logic                i_pause;
    logic                i_restart;
    logic                i_speed_up;
    logic                i_speed_down;
    logic                i_apple_ready;
    logic                i_tick_done;
    logic                i_eat;
    logic                i_failure;
    logic                i_success;
    logic                o_tick;
    logic [2:0]          o_state;
    logic                o_failure;
    logic                o_success;
    logic                o_fault;
    logic [SCORE_W-1:0]  o_score;
    logic [PERIOD_W-1:0] o_period;

    modport master (
        output i_vsync, i_start, i_pause, i_restart, i_speed_up, i_speed_down,
               i_apple_ready, i_tick_done, i_eat, i_failure, i_success,
        input  o_tick, o_state, o_failure, o_success, o_fault, o_score, o_period
    );

    modport slave (
        input  i_vsync, i_start, i_pause, i_restart, i_speed_up, i_speed_down,
               i_apple_ready, i_tick_done, i_eat, i_failure, i_success,
        output o_tick, o_state, o_failure, o_success, o_fault, o_score, o_period
    );

endinterface

// File: rtl/game_speed.sv
// Step period register: manual speed up/down plus one automatic speed-up
// every AUTO_EVERY apples, saturating at PERIOD_MIN/PERIOD_MAX.
module game_speed
    import game_pkg::*;
#(
    parameter int PERIOD_MAX = 15,
    parameter int PERIOD_MIN = 3,
    parameter int AUTO_EVERY = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                restart,
    input  logic                eat,
    input  logic                speed_up,
    input  logic                speed_down,
    output logic [PERIOD_W-1:0] period
);
    localparam int AW = (AUTO_EVERY > 1) ? $clog2(AUTO_EVERY) : 1;

    logic [AW-1:0] apple_cnt;
    logic          auto_dec;
    int            delta;

    assign auto_dec = eat && (apple_cnt == AW'(AUTO_EVERY - 1));

    // Opposing manual pulses cancel; the automatic step adds on top.
    always_comb begin
        delta = 0;
        if (auto_dec) delta = delta - 1;
        if (speed_up && !speed_down) delta = delta - 1;
        if (speed_down && !speed_up) delta = delta + 1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            apple_cnt <= '0;
            period    <= PERIOD_W'(PERIOD_MAX);
        end else begin
            if (eat) apple_cnt <= auto_dec ? '0 : apple_cnt + AW'(1);
            period <= sat_period(period, delta, PERIOD_MIN, PERIOD_MAX);
        end
    end

endmodule

// File: rtl/game_sched.sv
// Game-flow scheduler: frame counting, step tick issue with apple gating,
// tick_done watchdog, pause, sticky end-of-game flags and score.
//
//   state      | meaning
//   IDLE       | waiting for the player to start
//   RUN        | counting frames toward the next step
//   WAIT_APPLE | step due, apple not ready yet
//   WAIT_DONE  | tick issued, waiting for the snake's done pulse
//   PAUSE      | frame counting suspended
//   FAIL       | game lost (terminal)
//   WIN        | game won (terminal)
module game_sched
    import game_pkg::*;
#(
    parameter int PERIOD_MAX = 15,
    parameter int PERIOD_MIN = 3,
    parameter int AUTO_EVERY = 4,
    parameter int SCORE_W    = 8,
    parameter int TIMEOUT    = 1023
) (
    input  logic         clk,
    input  logic         rst_n,
    game_sched_if.slave  bus
);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam int FW   = PERIOD_W + 1;

    game_state_t         state, state_n;
    logic [PERIOD_W-1:0] frame_cnt, frame_n;
    logic [WD_W-1:0]     wd_cnt, wd_n;
    logic                tick_n, fail_set, win_set, fault_set;
    logic                live, step_due;

    game_speed #(
        .PERIOD_MAX (PERIOD_MAX),
        .PERIOD_MIN (PERIOD_MIN),
        .AUTO_EVERY (AUTO_EVERY)
    ) u_speed (
        .clk        (clk),
        .rst_n      (rst_n),
        .restart    (bus.i_restart),
        .eat        (bus.i_eat),
        .speed_up   (bus.i_speed_up),
        .speed_down (bus.i_speed_down),
        .period     (bus.o_period)
    );

    assign live     = state inside {RUN, WAIT_APPLE, WAIT_DONE, PAUSE};
    // >= rather than == so a period shortened under a running count fires next vsync.
    assign step_due = (FW'(frame_cnt) + FW'(1)) >= FW'(bus.o_period);
    assign bus.o_state = state;

    always_comb begin
        state_n   = state;
        frame_n   = frame_cnt;
        wd_n      = wd_cnt;
        tick_n    = 1'b0;
        fail_set  = 1'b0;
        win_set   = 1'b0;
        fault_set = 1'b0;
        if (live && bus.i_failure) begin
            state_n  = FAIL;
            fail_set = 1'b1;
        end else if (live && bus.i_success) begin
            state_n = WIN;
            win_set = 1'b1;
        end else begin
            case (state)
                IDLE: if (bus.i_start) begin
                    state_n = RUN;
                    frame_n = '0;
                end
                RUN: if (bus.i_pause) begin
                    state_n = PAUSE;
                end else if (bus.i_vsync) begin
                    if (step_due) begin
                        frame_n = '0;
                        if (bus.i_apple_ready) begin
                            state_n = WAIT_DONE;
                            tick_n  = 1'b1;
                            wd_n    = WD_W'(TIMEOUT);
                        end else begin
                            state_n = WAIT_APPLE;
                        end
                    end else begin
                        frame_n = frame_cnt + PERIOD_W'(1);
                    end
                end
                WAIT_APPLE: if (bus.i_apple_ready) begin
                    state_n = WAIT_DONE;
                    tick_n  = 1'b1;
                    wd_n    = WD_W'(TIMEOUT);
                end
                WAIT_DONE: if (bus.i_tick_done && !bus.o_tick) begin
                    state_n = RUN;
                end else if (wd_cnt == '0) begin
                    state_n   = FAIL;
                    fail_set  = 1'b1;
                    fault_set = 1'b1;
                end else begin
                    wd_n = wd_cnt - WD_W'(1);
                end
                PAUSE: if (!bus.i_pause) state_n = RUN;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || bus.i_restart) begin
            state         <= IDLE;
            frame_cnt     <= '0;
            wd_cnt        <= '0;
            bus.o_tick    <= 1'b0;
            bus.o_failure <= 1'b0;
            bus.o_success <= 1'b0;
            bus.o_fault   <= 1'b0;
            bus.o_score   <= '0;
        end else begin
            state      <= state_n;
            frame_cnt  <= frame_n;
            wd_cnt     <= wd_n;
            bus.o_tick <= tick_n;
            if (fail_set)  bus.o_failure <= 1'b1;
            if (win_set)   bus.o_success <= 1'b1;
            if (fault_set) bus.o_fault   <= 1'b1;
            if (bus.i_eat && (bus.o_score != '1)) bus.o_score <= bus.o_score + SCORE_W'(1);
        end
    end

endmodule

// File: tb/tb_game_sched.sv
// Directed self-checking bench for game_sched with hand-computed expectations.
module tb_game_sched;
    import game_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   fails = 0;
    int   tick_cnt = 0;
    int   t0;

    game_sched_if #(.SCORE_W(8)) bus ();

    game_sched #(
        .PERIOD_MAX (15),
        .PERIOD_MIN (3),
        .AUTO_EVERY (4),
        .SCORE_W    (8),
        .TIMEOUT    (1023)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.o_tick === 1'b1) tick_cnt++;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic vsync_pulse();
        bus.i_vsync = 1'b1;
        @(negedge clk);
        bus.i_vsync = 1'b0;
    endtask

    task automatic vsyncs(input int n);
        for (int i = 0; i < n; i++) begin
            vsync_pulse();
            @(negedge clk);
        end
    endtask

    task automatic spd_pulse(input logic eat, input logic up, input logic down);
        bus.i_eat = eat; bus.i_speed_up = up; bus.i_speed_down = down;
        @(negedge clk);
        bus.i_eat = 1'b0; bus.i_speed_up = 1'b0; bus.i_speed_down = 1'b0;
    endtask

    task automatic done_pulse();
        bus.i_tick_done = 1'b1;
        @(negedge clk);
        bus.i_tick_done = 1'b0;
    endtask

    task automatic restart_pulse();
        bus.i_restart = 1'b1;
        @(negedge clk);
        bus.i_restart = 1'b0;
    endtask

    task automatic start_pulse();
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        checks++; if (bus.o_state !== 3'(IDLE)) begin fails++; $display("FAIL reset_state: got %0d expected %0d", bus.o_state, 0); end
        checks++; if (bus.o_tick !== 1'b0) begin fails++; $display("FAIL reset_tick: got %b expected 0", bus.o_tick); end
        checks++; if ({bus.o_failure, bus.o_success, bus.o_fault} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b expected 000", {bus.o_failure, bus.o_success, bus.o_fault}); end
        checks++; if (bus.o_score !== 8'd0) begin fails++; $display("FAIL reset_score: got %0d expected 0", bus.o_score); end
        checks++; if (bus.o_period !== 4'd15) begin fails++; $display("FAIL reset_period: got %0d expected 15", bus.o_period); end
    endtask

    task automatic test_first_tick();
        bus.i_apple_ready = 1'b1;
        start_pulse();
        checks++; if (bus.o_state !== 3'(RUN)) begin fails++; $display("FAIL start_run: got %0d expected %0d", bus.o_state, 1); end
        t0 = tick_cnt;
        vsyncs(14);
        checks++; if (tick_cnt !== t0) begin fails++; $display("FAIL early_tick: got %0d ticks expected 0", tick_cnt - t0); end
        vsync_pulse();
        checks++; if (bus.o_tick !== 1'b1) begin fails++; $display("FAIL tick_after_15: got %b expected 1", bus.o_tick); end
        checks++; if (bus.o_state !== 3'(WAIT_DONE)) begin fails++; $display("FAIL state_wait_done: got %0d expected %0d", bus.o_state, 3); end
        cyc(1);
        checks++; if (bus.o_tick !== 1'b0) begin fails++; $display("FAIL tick_width: got %b expected 0", bus.o_tick); end
        cyc(3);
        done_pulse();
        checks++; if (bus.o_state !== 3'(RUN)) begin fails++; $display("FAIL done_to_run: got %0d expected %0d", bus.o_state, 1); end
        checks++; if (tick_cnt !== t0 + 1) begin fails++; $display("FAIL one_tick: got %0d ticks expected 1", tick_cnt - t0); end
    endtask

    task automatic test_wait_apple();
        bus.i_apple_ready = 1'b0;
        t0 = tick_cnt;
        vsyncs(15);
        checks++; if (bus.o_state !== 3'(WAIT_APPLE)) begin fails++; $display("FAIL wait_apple_state: got %0d expected %0d", bus.o_state, 2); end
        vsyncs(10);
        cyc(10);
        checks++; if (tick_cnt !== t0) begin fails++; $display("FAIL no_tick_unready: got %0d ticks expected 0", tick_cnt - t0); end
        bus.i_apple_ready = 1'b1;
        cyc(1);
        checks++; if (bus.o_tick !== 1'b1) begin fails++; $display("FAIL tick_on_ready: got %b expected 1", bus.o_tick); end
        vsyncs(20);
        checks++; if (tick_cnt !== t0 + 1) begin fails++; $display("FAIL single_outstanding: got %0d ticks expected 1", tick_cnt - t0); end
        checks++; if (bus.o_state !== 3'(WAIT_DONE)) begin fails++; $display("FAIL still_wait_done: got %0d expected %0d", bus.o_state, 3); end
        done_pulse();
        checks++; if (bus.o_state !== 3'(RUN)) begin fails++; $display("FAIL apple_done_run: got %0d expected %0d", bus.o_state, 1); end
    endtask

    task automatic test_speed();
        for (int i = 0; i < 8; i++) spd_pulse(1'b1, 1'b0, 1'b0);
        spd_pulse(1'b0, 1'b1, 1'b0);
        checks++; if (bus.o_score !== 8'd8) begin fails++; $display("FAIL score_8: got %0d expected 8", bus.o_score); end
        checks++; if (bus.o_period !== 4'd12) begin fails++; $display("FAIL period_12: got %0d expected 12", bus.o_period); end
        for (int i = 0; i < 20; i++) spd_pulse(1'b0, 1'b1, 1'b0);
        checks++; if (bus.o_period !== 4'd3) begin fails++; $display("FAIL period_min: got %0d expected 3", bus.o_period); end
        spd_pulse(1'b0, 1'b1, 1'b1);
        checks++; if (bus.o_period !== 4'd3) begin fails++; $display("FAIL up_down_same: got %0d expected 3", bus.o_period); end
        for (int i = 0; i < 3; i++) spd_pulse(1'b0, 1'b0, 1'b1);
        checks++; if (bus.o_period !== 4'd6) begin fails++; $display("FAIL period_6: got %0d expected 6", bus.o_period); end
        spd_pulse(1'b0, 1'b1, 1'b1);
        checks++; if (bus.o_period !== 4'd6) begin fails++; $display("FAIL up_down_mid: got %0d expected 6", bus.o_period); end
        for (int i = 0; i < 3; i++) spd_pulse(1'b1, 1'b0, 1'b0);
        spd_pulse(1'b1, 1'b1, 1'b0);
        checks++; if (bus.o_period !== 4'd4) begin fails++; $display("FAIL auto_plus_manual: got %0d expected 4", bus.o_period); end
        checks++; if (bus.o_score !== 8'd12) begin fails++; $display("FAIL score_12: got %0d expected 12", bus.o_score); end
        for (int i = 0; i < 15; i++) spd_pulse(1'b0, 1'b0, 1'b1);
        checks++; if (bus.o_period !== 4'd15) begin fails++; $display("FAIL period_max: got %0d expected 15", bus.o_period); end
    endtask

    task automatic test_pause();
        t0 = tick_cnt;
        vsyncs(5);
        bus.i_pause = 1'b1;
        cyc(1);
        checks++; if (bus.o_state !== 3'(PAUSE)) begin fails++; $display("FAIL pause_state: got %0d expected %0d", bus.o_state, 4); end
        vsyncs(3);
        bus.i_pause = 1'b0;
        cyc(1);
        checks++; if (bus.o_state !== 3'(RUN)) begin fails++; $display("FAIL unpause_run: got %0d expected %0d", bus.o_state, 1); end
        vsyncs(9);
        checks++; if (tick_cnt !== t0) begin fails++; $display("FAIL pause_no_tick: got %0d ticks expected 0", tick_cnt - t0); end
        vsync_pulse();
        checks++; if (bus.o_tick !== 1'b1) begin fails++; $display("FAIL pause_resume_tick: got %b expected 1", bus.o_tick); end
    endtask

    task automatic test_watchdog();
        cyc(1023);
        checks++; if (bus.o_fault !== 1'b0) begin fails++; $display("FAIL fault_early: got %b expected 0", bus.o_fault); end
        cyc(1);
        checks++; if ({bus.o_fault, bus.o_failure} !== 2'b11) begin fails++; $display("FAIL fault_1024: got %b expected 11", {bus.o_fault, bus.o_failure}); end
        checks++; if (bus.o_state !== 3'(FAIL)) begin fails++; $display("FAIL fault_state: got %0d expected %0d", bus.o_state, 5); end
    endtask

    task automatic test_restart();
        restart_pulse();
        checks++; if (bus.o_state !== 3'(IDLE)) begin fails++; $display("FAIL restart_state: got %0d expected %0d", bus.o_state, 0); end
        checks++; if (bus.o_score !== 8'd0) begin fails++; $display("FAIL restart_score: got %0d expected 0", bus.o_score); end
        checks++; if (bus.o_period !== 4'd15) begin fails++; $display("FAIL restart_period: got %0d expected 15", bus.o_period); end
        checks++; if ({bus.o_failure, bus.o_success, bus.o_fault} !== 3'b000) begin fails++; $display("FAIL restart_flags: got %b expected 000", {bus.o_failure, bus.o_success, bus.o_fault}); end
    endtask

    task automatic test_done_race();
        start_pulse();
        for (int i = 0; i < 12; i++) spd_pulse(1'b0, 1'b1, 1'b0);
        vsyncs(2);
        vsync_pulse();
        checks++; if (bus.o_tick !== 1'b1) begin fails++; $display("FAIL p3_tick: got %b expected 1", bus.o_tick); end
        done_pulse();
        checks++; if (bus.o_state !== 3'(WAIT_DONE)) begin fails++; $display("FAIL done_with_tick_ignored: got %0d expected %0d", bus.o_state, 3); end
        done_pulse();
        checks++; if (bus.o_state !== 3'(RUN)) begin fails++; $display("FAIL done_after_tick: got %0d expected %0d", bus.o_state, 1); end
    endtask

    task automatic test_fail_success();
        bus.i_failure = 1'b1; bus.i_success = 1'b1;
        cyc(1);
        bus.i_failure = 1'b0; bus.i_success = 1'b0;
        checks++; if (bus.o_state !== 3'(FAIL)) begin fails++; $display("FAIL both_state: got %0d expected %0d", bus.o_state, 5); end
        checks++; if ({bus.o_failure, bus.o_success, bus.o_fault} !== 3'b100) begin fails++; $display("FAIL both_flags: got %b expected 100", {bus.o_failure, bus.o_success, bus.o_fault}); end
        restart_pulse();
        bus.i_failure = 1'b1;
        cyc(1);
        bus.i_failure = 1'b0;
        checks++; if ({bus.o_state, bus.o_failure} !== {3'(IDLE), 1'b0}) begin fails++; $display("FAIL idle_ignores_failure: got %b expected 0000", {bus.o_state, bus.o_failure}); end
        start_pulse();
        bus.i_success = 1'b1;
        cyc(1);
        bus.i_success = 1'b0;
        checks++; if ({bus.o_state, bus.o_success} !== {3'(WIN), 1'b1}) begin fails++; $display("FAIL win: got %b expected 1101", {bus.o_state, bus.o_success}); end
        bus.i_failure = 1'b1;
        cyc(1);
        bus.i_failure = 1'b0;
        checks++; if ({bus.o_state, bus.o_failure} !== {3'(WIN), 1'b0}) begin fails++; $display("FAIL win_terminal: got %b expected 1100", {bus.o_state, bus.o_failure}); end
    endtask

    task automatic test_score_sat();
        restart_pulse();
        for (int i = 0; i < 260; i++) spd_pulse(1'b1, 1'b0, 1'b0);
        checks++; if (bus.o_score !== 8'd255) begin fails++; $display("FAIL score_sat: got %0d expected 255", bus.o_score); end
        checks++; if (bus.o_period !== 4'd3) begin fails++; $display("FAIL auto_to_min: got %0d expected 3", bus.o_period); end
    endtask

    initial begin
        bus.i_vsync = 1'b0; bus.i_start = 1'b0; bus.i_pause = 1'b0; bus.i_restart = 1'b0;
        bus.i_speed_up = 1'b0; bus.i_speed_down = 1'b0; bus.i_apple_ready = 1'b0;
        bus.i_tick_done = 1'b0; bus.i_eat = 1'b0; bus.i_failure = 1'b0; bus.i_success = 1'b0;
        @(negedge clk);
        test_reset();
        test_first_tick();
        test_wait_apple();
        test_speed();
        test_pause();
        test_watchdog();
        test_restart();
        test_done_race();
        test_fail_success();
        test_score_sat();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
